// File: rtl/bin_bcd.sv
// bin_bcd: registered 4-bit binary to 2-digit BCD converter, 1-cycle latency.
// Optional macro BIN_BCD_SEG_EN adds registered 7-segment outputs
// (active-high, bit order {g,f,e,d,c,b,a}) for both digits.
module bin_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] b,
    output logic [4:0] y,
    output logic       out_valid
`ifdef BIN_BCD_SEG_EN
    ,
    output logic [6:0] seg_units,
    output logic [6:0] seg_tens
`endif
);

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 5;

    localparam logic [IN_W-1:0] TEN = IN_W'(10);

    logic [OUT_W-1:0] y_c;

    // Compare/subtract core: values 10..15 carry into the tens digit.
    always_comb begin
        y_c = '0;
        if (b >= TEN) begin
            y_c = {1'b1, IN_W'(b - TEN)};
        end else begin
            y_c = {1'b0, b};
        end
    end

    // Result register; reset wins over conversion and discards the sampled b.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            y         <= y_c;
            out_valid <= 1'b1;
        end
    end

`ifdef BIN_BCD_SEG_EN
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_ONE   = SEG_W'(7'h06);
    localparam logic [SEG_W-1:0] SEG_ZERO  = SEG_W'(7'h3F);
    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(7'h00);

    logic [SEG_W-1:0] seg_units_c;
    logic [SEG_W-1:0] seg_tens_c;

    // Digit decoder for the units place; units never exceed 9.
    always_comb begin
        seg_units_c = SEG_BLANK;
        unique case (y_c[3:0])
            4'd0:    seg_units_c = SEG_W'(7'h3F);
            4'd1:    seg_units_c = SEG_W'(7'h06);
            4'd2:    seg_units_c = SEG_W'(7'h5B);
            4'd3:    seg_units_c = SEG_W'(7'h4F);
            4'd4:    seg_units_c = SEG_W'(7'h66);
            4'd5:    seg_units_c = SEG_W'(7'h6D);
            4'd6:    seg_units_c = SEG_W'(7'h7D);
            4'd7:    seg_units_c = SEG_W'(7'h07);
            4'd8:    seg_units_c = SEG_W'(7'h7F);
            4'd9:    seg_units_c = SEG_W'(7'h6F);
            default: seg_units_c = SEG_BLANK;
        endcase
    end

    // Tens digit is either blank (leading zero) or a one.
    always_comb begin
        seg_tens_c = SEG_BLANK;
        if (y_c[4]) begin
            seg_tens_c = SEG_ONE;
        end
    end

    // Segment registers track y on the same edge; reset shows a lone "0".
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_units <= SEG_ZERO;
            seg_tens  <= SEG_BLANK;
        end else begin
            seg_units <= seg_units_c;
            seg_tens  <= seg_tens_c;
        end
    end
`endif

endmodule

// File: tb/tb_bin_bcd.sv
// tb_bin_bcd: table-driven self-checking bench for bin_bcd.
// Define BIN_BCD_SEG_EN for both bench and design to cover the segment outputs.
`timescale 1ns/1ps
module tb_bin_bcd;

    logic       clk;
    logic       rst;
    logic [3:0] b;
    logic [4:0] y;
    logic       out_valid;
`ifdef BIN_BCD_SEG_EN
    logic [6:0] seg_units;
    logic [6:0] seg_tens;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] b;
        logic [4:0] y;
    } vec_t;

    vec_t vecs[16];

    bin_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .b         (b),
        .y         (y),
        .out_valid (out_valid)
`ifdef BIN_BCD_SEG_EN
        ,
        .seg_units (seg_units),
        .seg_tens  (seg_tens)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for the random section.
    function automatic logic [4:0] ref_conv(input logic [3:0] v);
        logic [4:0] r;
        case (v)
            4'd10:   r = 5'b10000;
            4'd11:   r = 5'b10001;
            4'd12:   r = 5'b10010;
            4'd13:   r = 5'b10011;
            4'd14:   r = 5'b10100;
            4'd15:   r = 5'b10101;
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd0,  5'b00000};
        vecs[1]  = '{4'd1,  5'b00001};
        vecs[2]  = '{4'd2,  5'b00010};
        vecs[3]  = '{4'd3,  5'b00011};
        vecs[4]  = '{4'd4,  5'b00100};
        vecs[5]  = '{4'd5,  5'b00101};
        vecs[6]  = '{4'd6,  5'b00110};
        vecs[7]  = '{4'd7,  5'b00111};
        vecs[8]  = '{4'd8,  5'b01000};
        vecs[9]  = '{4'd9,  5'b01001};
        vecs[10] = '{4'd10, 5'b10000};
        vecs[11] = '{4'd11, 5'b10001};
        vecs[12] = '{4'd12, 5'b10010};
        vecs[13] = '{4'd13, 5'b10011};
        vecs[14] = '{4'd14, 5'b10100};
        vecs[15] = '{4'd15, 5'b10101};

        rst = 1'b1;
        b   = 4'hF;

        // Reset held for two edges with b=F.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_y", 32'(y), 32'(5'b00000));
            check("reset_valid", 32'(out_valid), 32'(1'b0));
`ifdef BIN_BCD_SEG_EN
            check("reset_seg_units", 32'(seg_units), 32'(7'h3F));
            check("reset_seg_tens", 32'(seg_tens), 32'(7'h00));
`endif
        end
        rst = 1'b0;
        tick();
        check("post_reset_y", 32'(y), 32'(5'b10101));
        check("post_reset_valid", 32'(out_valid), 32'(1'b1));

        // Sweep 0..15 one per cycle; covers the 9->10 step on consecutive edges.
        for (int i = 0; i < 16; i++) begin
            b = vecs[i].b;
            tick();
            check($sformatf("sweep_y_b%0d", vecs[i].b), 32'(y), 32'(vecs[i].y));
            check("sweep_valid", 32'(out_valid), 32'(1'b1));
        end

        // Explicit boundary step 9 then 10.
        b = 4'd9;
        tick();
        check("step_y_9", 32'(y), 32'(5'b01001));
        b = 4'd10;
        tick();
        check("step_y_10", 32'(y), 32'(5'b10000));

        // Mid-stream single-cycle reset with b=13.
        b = 4'd13;
        tick();
        check("stream_y_13", 32'(y), 32'(5'b10011));
        rst = 1'b1;
        tick();
        check("mid_reset_y", 32'(y), 32'(5'b00000));
        check("mid_reset_valid", 32'(out_valid), 32'(1'b0));
        rst = 1'b0;
        tick();
        check("after_mid_reset_y", 32'(y), 32'(5'b10011));
        check("after_mid_reset_valid", 32'(out_valid), 32'(1'b1));

        // Random values against the reference, with the units-digit invariant.
        for (int i = 0; i < 10; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(15));
            b = r;
            tick();
            check($sformatf("rand_y_b%0d", r), 32'(y), 32'(ref_conv(r)));
            check("rand_units_le9", 32'(y[3:0] <= 4'd9), 32'(1'b1));
        end

`ifdef BIN_BCD_SEG_EN
        b = 4'd14;
        tick();
        check("seg_tens_14", 32'(seg_tens), 32'(7'h06));
        check("seg_units_14", 32'(seg_units), 32'(7'h66));
        b = 4'd3;
        tick();
        check("seg_tens_3", 32'(seg_tens), 32'(7'h00));
        check("seg_units_3", 32'(seg_units), 32'(7'h4F));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
